// File: rtl/conv_pkg.sv
// Shared constants and helpers for the 3x3 convolution core.
package conv_pkg;

  localparam int PIX_W = 8;

  localparam logic [1:0] MODE_PASS  = 2'd0;
  localparam logic [1:0] MODE_GAUSS = 2'd1;
  localparam logic [1:0] MODE_SOBEL = 2'd2;
  localparam logic [1:0] MODE_SHARP = 2'd3;

  // Clamp a signed 13-bit kernel result into an unsigned pixel.
  function automatic logic [PIX_W-1:0] sat_u8(input logic signed [12:0] v);
    if (v < 13'sd0)
      return '0;
    else if (v > 13'sd255)
      return '1;
    return v[PIX_W-1:0];
  endfunction

endpackage

// File: rtl/conv_pos_counter.sv
// Output column/row position tracking with registered line/frame pulses.
module conv_pos_counter #(
  parameter int IMG_COLS = 540,
  parameter int IMG_ROWS = 960,
  parameter int COL_W    = 10,
  parameter int ROW_W    = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             adv,
  input  logic             nxt_vld,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic             line_done,
  output logic             frame_done
);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_ROWS - 1);

  logic             col_last, row_last;
  logic [COL_W-1:0] col_inc, nxt_col;
  logic [ROW_W-1:0] row_inc, nxt_row;

  assign col_last = (col == COL_LAST);
  assign row_last = (row == ROW_LAST);
  assign col_inc  = col_last ? '0 : col + 1'b1;
  assign row_inc  = !col_last ? row : (row_last ? '0 : row + 1'b1);

  // While a pixel is on the output, the counters hold its position, so the
  // pixel about to enter the output register sits one step further on.
  assign nxt_col = adv ? col_inc : col;
  assign nxt_row = adv ? row_inc : row;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col        <= '0;
      row        <= '0;
      line_done  <= 1'b0;
      frame_done <= 1'b0;
    end else if (clr) begin
      col        <= '0;
      row        <= '0;
      line_done  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      if (adv) begin
        col <= col_inc;
        row <= row_inc;
      end
      line_done  <= nxt_vld && (nxt_col == COL_LAST);
      frame_done <= nxt_vld && (nxt_col == COL_LAST) && (nxt_row == ROW_LAST);
    end
  end

endmodule

// File: rtl/conv3x3_core.sv
// 3-stage 3x3 kernel core: pass / gauss / sobel magnitude / sharpen.
module conv3x3_core
  import conv_pkg::*;
#(
  parameter int IMG_COLS = 540,
  parameter int IMG_ROWS = 960,
  parameter int COL_W    = 10,
  parameter int ROW_W    = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             core_en_i,
  input  logic [1:0]       mode_i,
  input  logic             clr_i,
  input  logic [7:0]       data_0_0_i,
  input  logic [7:0]       data_0_1_i,
  input  logic [7:0]       data_0_2_i,
  input  logic [7:0]       data_1_0_i,
  input  logic [7:0]       data_1_1_i,
  input  logic [7:0]       data_1_2_i,
  input  logic [7:0]       data_2_0_i,
  input  logic [7:0]       data_2_1_i,
  input  logic [7:0]       data_2_2_i,
  output logic [7:0]       pixel_o,
  output logic             pixel_valid_o,
  output logic             line_done_o,
  output logic             frame_done_o,
  output logic             busy_o,
  output logic [COL_W-1:0] cnt_out_col_o,
  output logic [ROW_W-1:0] cnt_out_row_o
);

  localparam int STAGES = 3;

  logic [STAGES:1]                 vld_pipe;
  logic [2:0][2:0][PIX_W-1:0]      win_d, win1;
  logic [1:0]                      mode1, mode2;
  logic signed [12:0]              p [3][3];
  logic signed [12:0]              gauss, gx, gy, sharp, s2_a_d, s2_a;
  logic signed [10:0]              s2_b;
  logic [10:0]                     ax, ay;
  logic signed [12:0]              mag;
  logic [PIX_W-1:0]                res;

  assign win_d = {data_2_2_i, data_2_1_i, data_2_0_i,
                  data_1_2_i, data_1_1_i, data_1_0_i,
                  data_0_2_i, data_0_1_i, data_0_0_i};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     vld_pipe <= '0;
    else if (clr_i) vld_pipe <= '0;
    else            vld_pipe <= {vld_pipe[STAGES-1:1], core_en_i};
  end

  // S1: window capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win1  <= '0;
      mode1 <= MODE_PASS;
    end else if (core_en_i && !clr_i) begin
      win1  <= win_d;
      mode1 <= mode_i;
    end
  end

  // S2: signed kernel sums, 13 bits covers every mode's range
  always_comb begin
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        p[r][c] = $signed({5'b0, win1[r][c]});
    gauss = p[0][0] + (p[0][1] <<< 1) + p[0][2]
          + (p[1][0] <<< 1) + (p[1][1] <<< 2) + (p[1][2] <<< 1)
          + p[2][0] + (p[2][1] <<< 1) + p[2][2];
    gx    = (p[0][2] + (p[1][2] <<< 1) + p[2][2]) - (p[0][0] + (p[1][0] <<< 1) + p[2][0]);
    gy    = (p[2][0] + (p[2][1] <<< 1) + p[2][2]) - (p[0][0] + (p[0][1] <<< 1) + p[0][2]);
    sharp = (p[1][1] <<< 2) + p[1][1] - p[0][1] - p[1][0] - p[1][2] - p[2][1];
    case (mode1)
      MODE_GAUSS: s2_a_d = gauss;
      MODE_SOBEL: s2_a_d = gx;
      MODE_SHARP: s2_a_d = sharp;
      default:    s2_a_d = p[1][1];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_a  <= '0;
      s2_b  <= '0;
      mode2 <= MODE_PASS;
    end else if (vld_pipe[1] && !clr_i) begin
      s2_a  <= s2_a_d;
      s2_b  <= gy[10:0];
      mode2 <= mode1;
    end
  end

  // S3: shift / magnitude / clamp into the output register
  always_comb begin
    ax  = s2_a[10] ? -s2_a[10:0] : s2_a[10:0];
    ay  = s2_b[10] ? 11'(-s2_b)  : 11'(s2_b);
    mag = $signed({2'b0, ax}) + $signed({2'b0, ay});
    case (mode2)
      MODE_GAUSS: res = s2_a[11:4];
      MODE_SOBEL: res = sat_u8(mag);
      MODE_SHARP: res = sat_u8(s2_a);
      default:    res = s2_a[PIX_W-1:0];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           pixel_o <= '0;
    else if (clr_i)       pixel_o <= '0;
    else if (vld_pipe[2]) pixel_o <= res;
  end

  assign pixel_valid_o = vld_pipe[STAGES];
  assign busy_o        = |vld_pipe;

  conv_pos_counter #(
    .IMG_COLS (IMG_COLS),
    .IMG_ROWS (IMG_ROWS),
    .COL_W    (COL_W),
    .ROW_W    (ROW_W)
  ) u_pos (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr_i),
    .adv        (vld_pipe[STAGES]),
    .nxt_vld    (vld_pipe[STAGES-1]),
    .col        (cnt_out_col_o),
    .row        (cnt_out_row_o),
    .line_done  (line_done_o),
    .frame_done (frame_done_o)
  );

endmodule
